framebuffer_writer: RTL



---
 rtl/framebuffer_writer_if.sv | 28 ++
 rtl/framebuffer_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer_if.sv
// Pixel-producer and BRAM port-A signal bundle for framebuffer_writer.
// The slave modport is the writer's view; the master modport is the producer/BRAM side.
interface framebuffer_writer_if #(
  parameter int NUM_CH        = 2,
  parameter int COORD_BITS    = 16,
  parameter int COLOR_WIDTH   = 16,
  parameter int ADDR_BITS     = 18,
  parameter int DOUBLE_BUFFER = 1
);
  logic [NUM_CH-1:0]                  in_valid;
  logic [NUM_CH-1:0]                  in_ready;
  logic [NUM_CH*COORD_BITS-1:0]       in_x;
  logic [NUM_CH*COORD_BITS-1:0]       in_y;
  logic [NUM_CH*COLOR_WIDTH-1:0]      in_color;
  logic                               bram_we;
  logic [ADDR_BITS+DOUBLE_BUFFER-1:0] bram_addr;
  logic [COLOR_WIDTH-1:0]             bram_din;

  modport slave (
    input  in_valid, in_x, in_y, in_color,
    output in_ready, bram_we, bram_addr, bram_din
  );

  modport master (
    output in_valid, in_x, in_y, in_color,
    input  in_ready, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Frame buffer write port: round-robin producer arbitration, bounds check with
// saturating drop counter, hardware clear sweep and optional front/back swap.
module framebuffer_writer #(
  parameter int FRAME_WIDTH   = 512,
  parameter int FRAME_HEIGHT  = 384,
  parameter int COORD_BITS    = 16,
  parameter int COLOR_WIDTH   = 16,
  parameter int ADDR_BITS     = 18,
  parameter int NUM_CH        = 2,
  parameter int DOUBLE_BUFFER = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  framebuffer_writer_if.slave    bus,
  input  logic                   clear_req,
  input  logic [COLOR_WIDTH-1:0] clear_color,
  input  logic                   swap_req,
  output logic                   front_buf,
  output logic                   busy,
  output logic [15:0]            drop_count
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW      = ADDR_BITS + DOUBLE_BUFFER;
  localparam int PW      = ADDR_BITS + COORD_BITS;
  localparam logic [ADDR_BITS-1:0]  LAST_PIX = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] X_LIM    = COORD_BITS'(FRAME_WIDTH);
  localparam logic [COORD_BITS-1:0] Y_LIM    = COORD_BITS'(FRAME_HEIGHT);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]             r_state;
  logic [CH_BITS-1:0]     r_last_grant;
  logic                   r_front;
  logic                   r_swap_pending;
  logic [ADDR_BITS-1:0]   r_count;
  logic [COLOR_WIDTH-1:0] r_clr_color;
  logic [15:0]            r_drop;
  logic                   r_we;
  logic [AW-1:0]          r_addr;
  logic [COLOR_WIDTH-1:0] r_din;

  logic                   w_gnt_valid;
  logic [CH_BITS-1:0]     w_gnt_idx;
  logic [COORD_BITS-1:0]  w_x;
  logic [COORD_BITS-1:0]  w_y;
  logic [COLOR_WIDTH-1:0] w_color;
  logic                   w_in_range;
  logic [ADDR_BITS-1:0]   w_lin;
  logic                   w_back;
  logic [AW-1:0]          w_pix_addr;
  logic [AW-1:0]          w_clr_addr;
  logic                   w_accept;
  logic                   w_clr_last;
  logic                   w_swap_en;

  // Scan from the farthest candidate to the nearest so the channel right after
  // last_grant overrides everyone else.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [CH_BITS-1:0] cand;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = r_last_grant;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_BITS'((int'(r_last_grant) + k) % NUM_CH);
      if (bus.in_valid[cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = cand;
      end
    end
  end

  assign w_x        = bus.in_x[w_gnt_idx*COORD_BITS +: COORD_BITS];
  assign w_y        = bus.in_y[w_gnt_idx*COORD_BITS +: COORD_BITS];
  assign w_color    = bus.in_color[w_gnt_idx*COLOR_WIDTH +: COLOR_WIDTH];
  assign w_in_range = (w_x < X_LIM) && (w_y < Y_LIM);
  assign w_lin      = ADDR_BITS'(PW'(w_y) * PW'(FRAME_WIDTH) + PW'(w_x));
  assign w_back     = ~r_front;
  assign w_accept   = (r_state == ST_RUN) && !clear_req && w_gnt_valid;
  assign w_clr_last = (r_count == LAST_PIX);
  assign w_swap_en  = (DOUBLE_BUFFER != 0);

  generate
    if (DOUBLE_BUFFER != 0) begin : g_double
      assign w_pix_addr = {w_back, w_lin};
      assign w_clr_addr = {w_back, r_count};
    end else begin : g_single
      assign w_pix_addr = w_lin;
      assign w_clr_addr = r_count;
    end
  endgenerate

  always_comb begin
    bus.in_ready = '0;
    if (w_accept) bus.in_ready[w_gnt_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_last_grant   <= CH_BITS'(NUM_CH - 1);
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_count        <= '0;
      r_clr_color    <= '0;
      r_drop         <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_din          <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == ST_RUN) begin
        if (swap_req && w_swap_en) r_front <= ~r_front;
        if (clear_req) begin
          r_state     <= ST_CLEAR;
          r_count     <= '0;
          r_clr_color <= clear_color;
        end else if (w_accept) begin
          r_last_grant <= w_gnt_idx;
          if (w_in_range) begin
            r_we   <= 1'b1;
            r_addr <= w_pix_addr;
            r_din  <= w_color;
          end else if (r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
          end
        end
      end else begin
        r_we    <= 1'b1;
        r_addr  <= w_clr_addr;
        r_din   <= r_clr_color;
        r_count <= r_count + ADDR_BITS'(1);
        // A swap pending (or arriving now) lands on the exit edge, so the
        // buffer just cleared stays the back buffer for the whole sweep.
        if (w_clr_last) begin
          r_state        <= ST_RUN;
          r_swap_pending <= 1'b0;
          if (w_swap_en && (r_swap_pending || swap_req)) r_front <= ~r_front;
        end else if (swap_req && w_swap_en) begin
          r_swap_pending <= 1'b1;
        end
      end
    end
  end

  assign busy          = (r_state == ST_CLEAR);
  assign front_buf     = r_front;
  assign drop_count    = r_drop;
  assign bus.bram_we   = r_we;
  assign bus.bram_addr = r_addr;
  assign bus.bram_din  = r_din;
endmodule
